// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one 8x24 register file between the datapath (req 0)
// and the debug/exception unit (req 1). It registers every register-file control line.
module rf_port_arbiter #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] rb0,
    input  logic [ADDR_W-1:0] rw0,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] rb1,
    input  logic [ADDR_W-1:0] rw1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              r0_err,
    output logic [ADDR_W-1:0] rf_ra,
    output logic [ADDR_W-1:0] rf_rb,
    output logic [ADDR_W-1:0] rf_rw,
    output logic              rf_en_write,
    output logic [DATA_W-1:0] rf_busw,
    input  logic [DATA_W-1:0] rf_busa,
    input  logic [DATA_W-1:0] rf_busb
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              pend_q, pend_d;
    logic [1:0]        done_q, done_d;
    logic              r0_err_q, r0_err_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic [ADDR_W-1:0] rf_ra_q, rf_ra_d;
    logic [ADDR_W-1:0] rf_rb_q, rf_rb_d;
    logic [ADDR_W-1:0] rf_rw_q, rf_rw_d;
    logic              rf_en_write_q, rf_en_write_d;
    logic [DATA_W-1:0] rf_busw_q, rf_busw_d;

    logic              gnt;
    logic              wr_sel;
    logic [ADDR_W-1:0] rw_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            win_q         <= 1'b0;
            pend_q        <= 1'b0;
            done_q        <= 2'b00;
            r0_err_q      <= 1'b0;
            rdata_a_q     <= '0;
            rdata_b_q     <= '0;
            rf_ra_q       <= '0;
            rf_rb_q       <= '0;
            rf_rw_q       <= '0;
            rf_en_write_q <= 1'b0;
            rf_busw_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            win_q         <= win_d;
            pend_q        <= pend_d;
            done_q        <= done_d;
            r0_err_q      <= r0_err_d;
            rdata_a_q     <= rdata_a_d;
            rdata_b_q     <= rdata_b_d;
            rf_ra_q       <= rf_ra_d;
            rf_rb_q       <= rf_rb_d;
            rf_rw_q       <= rf_rw_d;
            rf_en_write_q <= rf_en_write_d;
            rf_busw_q     <= rf_busw_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        win_d         = win_q;
        pend_d        = pend_q;
        done_d        = 2'b00;
        r0_err_d      = 1'b0;
        rdata_a_d     = rdata_a_q;
        rdata_b_d     = rdata_b_q;
        rf_ra_d       = rf_ra_q;
        rf_rb_d       = rf_rb_q;
        rf_rw_d       = rf_rw_q;
        rf_en_write_d = rf_en_write_q;
        rf_busw_d     = rf_busw_q;
        gnt           = 1'b0;
        wr_sel        = 1'b0;
        rw_sel        = '0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester not served last wins.
                    gnt           = (req == 2'b11) ? ~last_q : req[1];
                    wr_sel        = gnt ? we[1] : we[0];
                    rw_sel        = gnt ? rw1 : rw0;
                    win_d         = gnt;
                    last_d        = gnt;
                    rf_ra_d       = gnt ? ra1 : ra0;
                    rf_rb_d       = gnt ? rb1 : rb0;
                    rf_rw_d       = rw_sel;
                    rf_busw_d     = gnt ? wdata1 : wdata0;
                    rf_en_write_d = wr_sel && (rw_sel != '0);
                    pend_d        = wr_sel && (rw_sel == '0);
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                rf_en_write_d = 1'b0;
                state_d       = CAPTURE;
            end
            CAPTURE: begin
                rdata_a_d = rf_busa;
                rdata_b_d = rf_busb;
                done_d    = win_q ? 2'b10 : 2'b01;
                r0_err_d  = pend_q;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign done        = done_q;
    assign r0_err      = r0_err_q;
    assign rdata_a     = rdata_a_q;
    assign rdata_b     = rdata_b_q;
    assign rf_ra       = rf_ra_q;
    assign rf_rb       = rf_rb_q;
    assign rf_rw       = rf_rw_q;
    assign rf_en_write = rf_en_write_q;
    assign rf_busw     = rf_busw_q;

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the single 8x24 register file (two registered read ports, one write port, writes sampled on the clock edge) between two requesters: req 0 is the multicycle datapath, req 1 is the debug/exception unit.
- Grants round-robin and drives the register-file address, write-enable and write-data lines from registers.
- Returns BusA/BusB read data to the winner with a one-cycle done pulse.
- Suppresses and flags writes to R0.

Parameters:
- DATA_W, 24, register data width.
- ADDR_W, 3, register address width (8 registers).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  request per requester; held high until done.
- we  in  2  write enable per requester; sampled with req.
- ra0, rb0, rw0  in  ADDR_W each  requester 0 read/write addresses.
- ra1, rb1, rw1  in  ADDR_W each  requester 1 read/write addresses.
- wdata0, wdata1  in  DATA_W each  write data per requester.
- done  out  2  one-cycle completion pulse to the granted requester.
- rdata_a, rdata_b  out  DATA_W each  captured BusA/BusB; valid while done is high and held until the next capture.
- r0_err  out  1  pulses with done when a write to R0 was suppressed.
- rf_ra, rf_rb, rf_rw  out  ADDR_W each  register-file addresses.
- rf_en_write  out  1  register-file write enable.
- rf_busw  out  DATA_W  register-file write data.
- rf_busa, rf_busb  in  DATA_W each  register-file read data, registered inside the register file.

Behaviour:
- Reset (async, active-high): state=IDLE; last-served pointer=1, so requester 0 wins the first tie.
  - done=0, r0_err=0, rdata_a=rdata_b=0.
  - rf_ra=rf_rb=rf_rw=0, rf_en_write=0, rf_busw=0.
  - The register file's own active-low reset is driven at top level, not here.
- All outputs are registered.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that requester.
  - Both reqs: grant the requester other than the last-served one.
  - On grant: latch winner id and update the pointer.
  - Drive rf_ra, rf_rb, rf_rw, rf_busw from the winner.
  - rf_en_write = winner's we AND (rw != 0).
  - r0_err_pending = winner's we AND (rw == 0).
  - Next state ISSUE.
- ISSUE: rf_* held stable; the register file samples addresses and performs the write at the end of this cycle. Next state CAPTURE, with rf_en_write cleared on entry.
- CAPTURE:
  - rf_busa/rf_busb hold the read data; latch them into rdata_a/rdata_b.
  - Set done[winner]=1 and r0_err=r0_err_pending.
  - Next state RESP.
- RESP:
  - done/r0_err visible for exactly this cycle.
  - req is ignored; the requester drops req by the end of RESP.
  - Next state IDLE; done/r0_err clear.
- Latency: req sampled at edge N → write committed at edge N+1 → done high for the cycle after edge N+2. Throughput is one access per 4 cycles.
- Read data is the pre-write value when ra/rb == rw, because the register file reads before it writes in the same edge.
- A read of R0 is legal. A write to R0 never asserts rf_en_write.
- A req change during ISSUE/CAPTURE/RESP has no effect; the latched access completes.
- A req still high in IDLE after done starts a new access.
- Reset mid-access: rf_en_write drops immediately. No done is issued. The write is lost only if reset asserts before the ISSUE-end edge.
- Exactly one done bit is ever high; done and r0_err are never high in IDLE/ISSUE.

Test Plan:
- Reset, then req0 write R3=0x00ABCD (we0=1, rw0=3) → rf_en_write=1 with rf_rw=3 for the ISSUE cycle; done=2'b01 3 edges after req; r0_err=0.
- req0 read ra0=3, rb0=0 after the write → rdata_a=0x00ABCD, rdata_b = R0 contents; done=2'b01.
- req0 and req1 held high together → grants alternate 0,1,0,1; done is never 2'b11; each access is 4 cycles.
- req1 write rw1=0, wdata1=0x123456 → rf_en_write stays 0; r0_err=1 together with done=2'b10; a later read of R0 is unchanged.
- req0 write R5=0x000777 while ra0=5 → rdata_a = old R5 value; a following read returns 0x000777.
- Assert reset during ISSUE → all outputs 0 immediately, state IDLE, no done pulse; a subsequent req0 completes normally.
